// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and address-split helpers for the direct-mapped cache
package cache_pkg;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  // Marks the COMPARE that re-runs a request after refill; it must not bump hit_cnt.
  localparam logic HIT_REPLAY = 1'b1;

  function automatic int clog2i(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int off_bits(input int words_per_block);
    return clog2i(words_per_block);
  endfunction

  function automatic int idx_bits(input int lines);
    return clog2i(lines);
  endfunction

  function automatic int tag_bits(input int addr_w, input int words_per_block, input int lines);
    return addr_w - off_bits(words_per_block) - idx_bits(lines) - 2;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// rtl/cache_line_store.sv - valid/dirty/tag/data arrays with one read port and a word-or-block write port
module cache_line_store #(
  parameter int WORD_W = 32,
  parameter int WPB    = 16,
  parameter int LINES  = 64,
  parameter int TAG_W  = 20,
  parameter int IDX_W  = 6,
  parameter int OFF_W  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IDX_W-1:0]             idx,
  output logic                         line_valid,
  output logic                         line_dirty,
  output logic [TAG_W-1:0]             line_tag,
  output logic [WPB-1:0][WORD_W-1:0]   line_block,
  input  logic                         wr_word,
  input  logic [OFF_W-1:0]             wr_off,
  input  logic [WORD_W-1:0]            wr_wdata,
  input  logic                         wr_block,
  input  logic [TAG_W-1:0]             wr_tag,
  input  logic [WPB-1:0][WORD_W-1:0]   wr_bdata
);

  logic [LINES-1:0]                valid_q;
  logic [LINES-1:0]                dirty_q;
  logic [TAG_W-1:0]                tag_q  [LINES];
  logic [WPB-1:0][WORD_W-1:0]      data_q [LINES];

  assign line_valid = valid_q[idx];
  assign line_dirty = dirty_q[idx];
  assign line_tag   = tag_q[idx];
  assign line_block = data_q[idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_block) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (wr_word) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: valid gates every use of them.
  always_ff @(posedge clk) begin
    if (wr_block) begin
      tag_q[idx]  <= wr_tag;
      data_q[idx] <= wr_bdata;
    end else if (wr_word) begin
      data_q[idx][wr_off] <= wr_wdata;
    end
  end

endmodule

// File: rtl/cache_dm.sv
// rtl/cache_dm.sv - direct-mapped write-back write-allocate cache: FSM, request latches and counters
module cache_dm
  import cache_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int WORD_W          = 32,
  parameter int WORDS_PER_BLOCK = 16,
  parameter int LINES           = 64,
  parameter int CNT_W           = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cpu_req,
  input  logic                              cpu_we,
  input  logic [ADDR_W-1:0]                 cpu_addr,
  input  logic [WORD_W-1:0]                 cpu_wdata,
  output logic                              cpu_ready,
  output logic [WORD_W-1:0]                 cpu_rdata,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [WORD_W*WORDS_PER_BLOCK-1:0] mem_wdata,
  input  logic [WORD_W*WORDS_PER_BLOCK-1:0] mem_rdata,
  input  logic                              mem_ack,
  output logic [CNT_W-1:0]                  hit_cnt,
  output logic [CNT_W-1:0]                  miss_cnt
);

  localparam int OFF_W = off_bits(WORDS_PER_BLOCK);
  localparam int IDX_W = idx_bits(LINES);
  localparam int TAG_W = tag_bits(ADDR_W, WORDS_PER_BLOCK, LINES);

  state_t                                  state;
  logic                                    replay;
  logic [ADDR_W-3:0]                       waddr_q;
  logic                                    we_q;
  logic [WORD_W-1:0]                       wdata_q;
  logic [OFF_W-1:0]                        off_q;
  logic [IDX_W-1:0]                        idx_q;
  logic [TAG_W-1:0]                        tag_q;
  logic                                    line_valid;
  logic                                    line_dirty;
  logic [TAG_W-1:0]                        line_tag;
  logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0]  line_block;
  logic                                    hit;
  logic                                    wr_word;
  logic                                    wr_block;
  logic                                    unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];

  assign off_q = waddr_q[OFF_W-1:0];
  assign idx_q = waddr_q[OFF_W+IDX_W-1:OFF_W];
  assign tag_q = waddr_q[ADDR_W-3:OFF_W+IDX_W];

  assign hit      = line_valid && (line_tag == tag_q);
  assign wr_word  = (state == COMPARE) && hit && we_q;
  assign wr_block = (state == ALLOCATE) && mem_req && mem_ack;

  cache_line_store #(
    .WORD_W (WORD_W),
    .WPB    (WORDS_PER_BLOCK),
    .LINES  (LINES),
    .TAG_W  (TAG_W),
    .IDX_W  (IDX_W),
    .OFF_W  (OFF_W)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .idx        (idx_q),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .line_tag   (line_tag),
    .line_block (line_block),
    .wr_word    (wr_word),
    .wr_off     (off_q),
    .wr_wdata   (wdata_q),
    .wr_block   (wr_block),
    .wr_tag     (tag_q),
    .wr_bdata   (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      replay    <= ~HIT_REPLAY;
      waddr_q   <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            waddr_q <= cpu_addr[ADDR_W-1:2];
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
            state   <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            cpu_ready <= 1'b1;
            if (!we_q) cpu_rdata <= line_block[off_q];
            if (replay != HIT_REPLAY && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            replay <= ~HIT_REPLAY;
            state  <= IDLE;
          end else begin
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            mem_req <= 1'b1;
            if (line_valid && line_dirty) begin
              mem_we    <= 1'b1;
              mem_addr  <= {line_tag, idx_q, {(OFF_W+2){1'b0}}};
              mem_wdata <= line_block;
              state     <= WRITEBACK;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= {tag_q, idx_q, {(OFF_W+2){1'b0}}};
              state    <= ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          // Dropping mem_req here yields the idle cycle before the fetch is issued.
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            state     <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= {tag_q, idx_q, {(OFF_W+2){1'b0}}};
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            replay  <= HIT_REPLAY;
            state   <= COMPARE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
